// File: rtl/tick_ctrl_if.sv
// Command and tick-handshake bundle between a host, the tick controller and the core.
// The controller connects through "slave"; the host/core side uses "master".
interface tick_ctrl_if #(
   parameter int DIV_W = 32,
   parameter int CNT_W = 32
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [DIV_W-1:0] cmd_data;
   logic             tick;
   logic             tick_done;
   logic             running;
   logic             busy;
   logic             overrun;
   logic [CNT_W-1:0] tick_count;

   modport master (
      output cmd_valid, cmd_op, cmd_data, tick_done,
      input  cmd_ready, tick, running, busy, overrun, tick_count
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_data, tick_done,
      output cmd_ready, tick, running, busy, overrun, tick_count
   );
endinterface

// File: rtl/tick_ctrl.sv
// Simulation tick scheduler: a prescaled period issues one tick at a time to the core,
// deferring at most one tick while the core is busy and flagging the overrun.
module tick_ctrl #(
   parameter int DIV_W          = 32,
   parameter int CNT_W          = 32,
   parameter int DEFAULT_PERIOD = 50000
) (
   input  logic clk_in,
   input  logic rst,
   tick_ctrl_if.slave bus
);
   localparam int               DEF_I = (DEFAULT_PERIOD < 1) ? 1 : DEFAULT_PERIOD;
   localparam logic [DIV_W-1:0] DEF_P = DIV_W'(DEF_I);

   localparam logic [1:0] OP_STOP = 2'b00;
   localparam logic [1:0] OP_RUN  = 2'b01;
   localparam logic [1:0] OP_STEP = 2'b10;
   localparam logic [1:0] OP_SET  = 2'b11;

   typedef enum logic [1:0] {IDLE, RUN, STEP, DRAIN} state_e;

   state_e           state_q, state_d;
   logic [DIV_W-1:0] period_q, period_d;
   logic [DIV_W-1:0] pre_q, pre_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick_q, busy_q, busy_d, pend_q, pend_d, ovr_q, ovr_d;

   logic             cmd_ready, acc, done_eff, busy_eff, elapse, issue;
   logic [DIV_W-1:0] new_period;

   assign cmd_ready  = !rst && (state_q == IDLE || state_q == RUN);
   assign acc        = bus.cmd_valid && cmd_ready;
   // A done pulse only counts for a tick already seen by the core.
   assign done_eff   = bus.tick_done && busy_q && !tick_q;
   assign busy_eff   = busy_q && !done_eff;
   assign elapse     = (state_q == RUN) && (pre_q == period_q - DIV_W'(1));
   assign new_period = (bus.cmd_data == '0) ? DIV_W'(1) : bus.cmd_data;

   always_comb begin
      state_d  = state_q;
      period_d = period_q;
      pre_d    = pre_q;
      pend_d   = pend_q;
      ovr_d    = ovr_q;
      issue    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (acc) begin
               unique case (bus.cmd_op)
                  OP_RUN:  begin pre_d = '0; ovr_d = 1'b0; state_d = RUN; end
                  OP_STEP: begin issue = 1'b1; state_d = STEP; end
                  OP_SET:  begin period_d = new_period; pre_d = '0; end
                  default: ;
               endcase
            end
         end
         RUN: begin
            pre_d = elapse ? '0 : pre_q + DIV_W'(1);
            if (acc && bus.cmd_op == OP_STOP) begin
               pend_d  = 1'b0;
               state_d = busy_eff ? DRAIN : IDLE;
            end else begin
               if (acc && bus.cmd_op == OP_SET) begin
                  period_d = new_period;
                  pre_d    = '0;
               end
               // Deferred tick wins; a coincident elapse folds into it.
               if (done_eff && pend_q) begin
                  issue  = 1'b1;
                  pend_d = 1'b0;
               end else if (elapse) begin
                  if (busy_eff) begin
                     ovr_d  = 1'b1;
                     pend_d = 1'b1;
                  end else begin
                     issue = 1'b1;
                  end
               end
            end
         end
         STEP, DRAIN: begin
            if (done_eff) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = issue ? 1'b1 : busy_eff;
      cnt_d  = cnt_q + CNT_W'(issue);
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         state_q  <= IDLE;
         period_q <= DEF_P;
         pre_q    <= '0;
         cnt_q    <= '0;
         tick_q   <= 1'b0;
         busy_q   <= 1'b0;
         pend_q   <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         period_q <= period_d;
         pre_q    <= pre_d;
         cnt_q    <= cnt_d;
         tick_q   <= issue;
         busy_q   <= busy_d;
         pend_q   <= pend_d;
         ovr_q    <= ovr_d;
      end
   end

   assign bus.cmd_ready  = cmd_ready;
   assign bus.tick       = tick_q;
   assign bus.busy       = busy_q;
   assign bus.overrun    = ovr_q;
   assign bus.running    = (state_q == RUN);
   assign bus.tick_count = cnt_q;
endmodule
